// File: rtl/vc_input_port.sv
// vc_input_port: per-VC flit FIFOs, credit output and packet FSM per VC.
// Defining VCIP_ERR_CNT_EN adds a saturating 8-bit error counter on err_cnt.
module vc_input_port #(
    parameter int FLIT_W = 128,
    parameter int DEST_W = 8,
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [$clog2(NUM_VC)-1:0]             wr_vc,
    input  logic [FLIT_W-1:0]                     wr_data,
    input  logic                                  rd_en,
    input  logic [$clog2(NUM_VC)-1:0]             rd_vc,
    output logic [FLIT_W-1:0]                     rd_data,
    output logic                                  rd_valid,
    output logic [NUM_VC*$clog2(DEPTH+1)-1:0]     em_pl,
    output logic [NUM_VC-1:0]                     vc_req,
    output logic [NUM_VC*DEST_W-1:0]              head_dest,
    input  logic [NUM_VC-1:0]                     vc_grant,
    output logic                                  err,
    output logic [7:0]                            err_cnt
);

    localparam int VCW  = $clog2(NUM_VC);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    localparam logic [VCW:0]    NVC  = (VCW + 1)'(NUM_VC);

    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_t;

    logic [FLIT_W-1:0] mem    [NUM_VC][DEPTH];
    logic [PW-1:0]     wr_ptr [NUM_VC];
    logic [PW-1:0]     rd_ptr [NUM_VC];
    logic [CNTW-1:0]   count  [NUM_VC];
    state_t            state  [NUM_VC];
    state_t            state_nx [NUM_VC];
    logic [FLIT_W-1:0] front  [NUM_VC];

    logic [NUM_VC-1:0] nonempty;
    logic [NUM_VC-1:0] discard;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic              wr_vc_ok;
    logic              rd_vc_ok;
    logic              rd_ok;
    logic              wr_ok;
    logic              err_nx;

    // Per-VC front flit, occupancy and stray-body discard detection
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            front[v]    = mem[v][rd_ptr[v]];
            nonempty[v] = count[v] != '0;
            discard[v]  = (state[v] == IDLE) && nonempty[v] && !front[v][0];
        end
    end

    assign wr_vc_ok = {1'b0, wr_vc} < NVC;
    assign rd_vc_ok = {1'b0, rd_vc} < NVC;
    // A read needs data already stored, so a write to an empty VC never bypasses
    assign rd_ok = rd_en && rd_vc_ok && nonempty[rd_vc] && (state[rd_vc] == ACTIVE);
    // A full VC still accepts a write when the same VC is legally read this cycle
    assign wr_ok = wr_en && wr_vc_ok &&
                   ((count[wr_vc] != FULL) || (rd_ok && (rd_vc == wr_vc)));
    assign err_nx = (wr_en && !wr_ok) || (rd_en && !rd_ok) || (|discard);

    // Decode push/pop per VC; a discard pops without producing output
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            push[v] = wr_ok && (wr_vc == VCW'(v));
            pop[v]  = (rd_ok && (rd_vc == VCW'(v))) || discard[v];
        end
    end

    // Next-state logic for each VC packet FSM
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            state_nx[v] = state[v];
            unique case (state[v])
                IDLE:    if (nonempty[v] && front[v][0]) state_nx[v] = ROUTE;
                ROUTE:   if (vc_grant[v]) state_nx[v] = ACTIVE;
                ACTIVE:  if (rd_ok && (rd_vc == VCW'(v)) && front[v][1])
                             state_nx[v] = IDLE;
                default: state_nx[v] = IDLE;
            endcase
        end
    end

    // Pointers, occupancy and FSM state; reset discards all contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
                state[v]  <= IDLE;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                count[v] <= count[v] + CNTW'(push[v]) - CNTW'(pop[v]);
                state[v] <= state_nx[v];
            end
        end
    end

    // Flit storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_vc][wr_ptr[wr_vc]] <= wr_data;
    end

    // Registered read data, valid and error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (rd_ok) rd_data <= front[rd_vc];
            rd_valid <= rd_ok;
            err      <= err_nx;
        end
    end

    // Credits, route requests and front-flit destinations
    always_comb begin
        em_pl     = '0;
        vc_req    = '0;
        head_dest = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            em_pl[v*CNTW +: CNTW] = FULL - count[v];
            vc_req[v] = state[v] == ROUTE;
            if (nonempty[v])
                head_dest[v*DEST_W +: DEST_W] = front[v][FLIT_W-15 -: DEST_W];
        end
    end

`ifdef VCIP_ERR_CNT_EN
    // Saturating count of error pulses, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt <= 8'd0;
        else if (err_nx && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vc_input_port.sv
// tb_vc_input_port: directed checks of vc_input_port with default parameters.
// Expected flits come from the bench's own flit builder and hand-derived constants.
module tb_vc_input_port;

    logic         clk;
    logic         reset;
    logic         wr_en;
    logic [1:0]   wr_vc;
    logic [127:0] wr_data;
    logic         rd_en;
    logic [1:0]   rd_vc;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic [15:0]  em_pl;
    logic [3:0]   vc_req;
    logic [31:0]  head_dest;
    logic [3:0]   vc_grant;
    logic         err;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    logic [127:0] f0 [20];
    logic [127:0] f2 [20];
    logic [127:0] fl [9];
    logic [127:0] h;
    logic [7:0]   exp_cnt;

    vc_input_port dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data), .rd_valid(rd_valid),
        .em_pl(em_pl), .vc_req(vc_req), .head_dest(head_dest),
        .vc_grant(vc_grant), .err(err), .err_cnt(err_cnt)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] got,
                       input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkflit(input logic [1:0] t,
                                            input logic [7:0] d,
                                            input logic [15:0] p);
        logic [127:0] f;
        f = '0;
        f[1:0] = t;
        f[113:106] = d;
        f[47:32] = p;
        return f;
    endfunction

    // One clock cycle of stimulus; returns 1 time unit after the edge
    task automatic cyc(input logic w, input logic [1:0] wv, input logic [127:0] wd,
                       input logic r, input logic [1:0] rv, input logic [3:0] g);
        wr_en = w; wr_vc = wv; wr_data = wd;
        rd_en = r; rd_vc = rv; vc_grant = g;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; vc_grant = 4'b0;
    endtask

    task automatic rst_pulse();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        wr_en = 0; wr_vc = 0; wr_data = '0;
        rd_en = 0; rd_vc = 0; vc_grant = 0;
        #12;
        chk("rst_em_pl", em_pl, 16'h8888);
        chk("rst_req_dest", {vc_req, head_dest}, 36'h0);
        chk("rst_rd", {rd_valid, rd_data}, 129'h0);
        chk("rst_err", {err, err_cnt}, 9'h0);
        reset = 1'b0;

        // Packet of five flits into VC1
        fl[0] = mkflit(2'b01, 8'h9F, 16'h0100);
        fl[1] = mkflit(2'b00, 8'h00, 16'h0101);
        fl[2] = mkflit(2'b00, 8'h00, 16'h0102);
        fl[3] = mkflit(2'b00, 8'h00, 16'h0103);
        fl[4] = mkflit(2'b10, 8'h00, 16'h0104);
        for (int i = 0; i < 5; i++) cyc(1, 2'd1, fl[i], 0, 0, 0);
        chk("t1_em_pl", em_pl, 16'h8838);
        chk("t1_vc_req", vc_req, 4'b0010);
        chk("t1_head_dest", head_dest, 32'h0000_9F00);

        // Grant VC1 and drain it in order
        cyc(0, 0, '0, 0, 0, 4'b0010);
        chk("t2_req_after_grant", vc_req, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, '0, 1, 2'd1, 0);
            chk($sformatf("t2_rd%0d", i), {rd_valid, rd_data}, {1'b1, fl[i]});
        end
        chk("t2_em_pl", em_pl, 16'h8888);
        chk("t2_idle", {vc_req, err}, 5'b0);

        // Overfill VC0
        for (int i = 0; i < 9; i++) begin
            fl[i] = mkflit(i == 0 ? 2'b01 : 2'b00, 8'h55, 16'(16'h0200 + i));
            cyc(1, 2'd0, fl[i], 0, 0, 0);
            if (i == 7) chk("t3_err_at_full", err, 1'b0);
        end
        chk("t3_err_overflow", err, 1'b1);
        chk("t3_em_pl_full", em_pl, 16'h8880);
        chk("t3_req", vc_req, 4'b0001);
        cyc(0, 0, '0, 0, 0, 4'b0001);
        cyc(1, 2'd0, mkflit(2'b00, 8'h00, 16'h02AA), 1, 2'd0, 0);
        chk("t3_rw_data", {rd_valid, rd_data}, {1'b1, fl[0]});
        chk("t3_rw_err", err, 1'b0);
        chk("t3_rw_em_pl", em_pl, 16'h8880);
        cyc(0, 0, '0, 1, 2'd0, 0);
        chk("t3_rd_next", {rd_valid, rd_data}, {1'b1, fl[1]});
        chk("t3_em_pl_one", em_pl, 16'h8881);

        // Illegal reads: empty VC2, VC3 still in ROUTE
        rst_pulse();
        cyc(0, 0, '0, 1, 2'd2, 0);
        chk("t4_empty_rd", {rd_valid, err}, 2'b01);
        h = mkflit(2'b01, 8'hC3, 16'h0300);
        cyc(1, 2'd3, h, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk("t4_req", vc_req, 4'b1000);
        cyc(0, 0, '0, 1, 2'd3, 0);
        chk("t4_route_rd", {rd_valid, err}, 2'b01);
        chk("t4_rd_data_held", rd_data, 128'h0);
`ifdef VCIP_ERR_CNT_EN
        exp_cnt = 8'd2;
`else
        exp_cnt = 8'd0;
`endif
        chk("t4_err_cnt", err_cnt, exp_cnt);

        // Interleaved 20-flit packets on VC0 and VC2, pointers wrap twice
        rst_pulse();
        for (int i = 0; i < 20; i++) begin
            f0[i] = mkflit(i == 0 ? 2'b01 : (i == 19 ? 2'b10 : 2'b00),
                           i == 0 ? 8'h11 : 8'h00, 16'(16'h0000 + i));
            f2[i] = mkflit(i == 0 ? 2'b01 : (i == 19 ? 2'b10 : 2'b00),
                           i == 0 ? 8'h22 : 8'h00, 16'(16'h0200 + i));
        end
        cyc(1, 2'd0, f0[0], 0, 0, 0);
        cyc(1, 2'd2, f2[0], 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk("t5_req", vc_req, 4'b0101);
        chk("t5_dest", head_dest, 32'h0022_0011);
        cyc(0, 0, '0, 0, 0, 4'b0101);
        for (int i = 1; i < 20; i++) begin
            cyc(1, 2'd0, f0[i], 1, 2'd2, 0);
            chk($sformatf("t5_vc2_%0d", i - 1), {rd_valid, rd_data}, {1'b1, f2[i-1]});
            cyc(1, 2'd2, f2[i], 1, 2'd0, 0);
            chk($sformatf("t5_vc0_%0d", i - 1), {rd_valid, rd_data}, {1'b1, f0[i-1]});
        end
        cyc(0, 0, '0, 1, 2'd0, 0);
        chk("t5_vc0_19", {rd_valid, rd_data}, {1'b1, f0[19]});
        cyc(0, 0, '0, 1, 2'd2, 0);
        chk("t5_vc2_19", {rd_valid, rd_data}, {1'b1, f2[19]});
        chk("t5_end", {em_pl, vc_req, err}, {16'h8888, 4'b0, 1'b0});

        // Asynchronous reset in the middle of a VC1 packet
        h = mkflit(2'b01, 8'h77, 16'h0600);
        cyc(1, 2'd1, h, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(1, 2'd1, mkflit(2'b00, 8'h00, 16'h0601), 0, 0, 4'b0010);
        cyc(0, 0, '0, 1, 2'd1, 0);
        chk("t6_pre_rd", {rd_valid, rd_data}, {1'b1, h});
        chk("t6_pre_em_pl", em_pl, 16'h8878);
        #1 reset = 1'b1;
        #1;
        chk("t6_async_rd", {rd_valid, rd_data}, 129'h0);
        chk("t6_async_misc", {em_pl, vc_req, head_dest, err, err_cnt},
            {16'h8888, 4'b0, 32'h0, 1'b0, 8'h0});
        #1 reset = 1'b0;
        h = mkflit(2'b11, 8'h3C, 16'h0700);
        cyc(1, 2'd1, h, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk("t6_req", {vc_req, head_dest}, {4'b0010, 32'h0000_3C00});
        cyc(0, 0, '0, 0, 0, 4'b0010);
        cyc(0, 0, '0, 1, 2'd1, 0);
        chk("t6_single", {rd_valid, rd_data}, {1'b1, h});
        chk("t6_idle", {em_pl, vc_req, err}, {16'h8888, 4'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
